// File: rtl/spi_pkg.sv
// Shared constants for the SPI master arbiter slice.
// Holds the default packet width and requester count, the write-bit position
// inside an emesh packet, and the requester-ID width helper (clog2 of N).
package spi_pkg;

  localparam int unsigned N_DEF  = 2;
  localparam int unsigned PW_DEF = 104;
  localparam int unsigned WR_BIT = 0;

  // Requester-ID width; N is at least 2, so this never collapses to zero.
  function automatic int unsigned id_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_arb_idfifo.sv
// Outstanding-read ID FIFO: remembers which requester issued each read so the
// SPI readback can be routed back in issue order.
// Ports:
//   clk, nreset       clock, async active-low reset (FIFO empties on reset)
//   push, din         write an ID (ignored while full)
//   pop               drop the head ID (ignored while empty)
//   full, empty       occupancy flags
//   head              ID at the head of the FIFO
module spi_arb_idfifo #(
  parameter int unsigned W     = 1,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int unsigned AW = (DEPTH < 2) ? 1 : $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  // Pointers and occupancy; power-of-2 depth lets pointers wrap naturally.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/spi_master_arb.sv
// Arbitrates N emesh requesters onto one SPI master register port and routes
// SPI readbacks to the requester that issued each read.
// Build option: define SPI_ARB_FIXED_PRIO_EN for lowest-index-wins priority;
// default build is round-robin starting after the last granted requester.
// Ports:
//   clk, nreset                    clock, async active-low reset
//   req_access/req_packet/req_wait requester side (packet i at [i*PW +: PW])
//   spi_access/spi_packet/spi_wait registered request toward the SPI master
//   rsp_access/rsp_packet/rsp_wait readback from the SPI master
//   ret_access/ret_packet/ret_wait readback toward requesters (one-hot access)
//   orphan                         sticky: readback arrived with nothing outstanding
module spi_master_arb
  import spi_pkg::*;
#(
  parameter int unsigned N     = N_DEF,
  parameter int unsigned PW    = PW_DEF,
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic [N-1:0]    req_access,
  input  logic [N*PW-1:0] req_packet,
  output logic [N-1:0]    req_wait,
  output logic            spi_access,
  output logic [PW-1:0]   spi_packet,
  input  logic            spi_wait,
  input  logic            rsp_access,
  input  logic [PW-1:0]   rsp_packet,
  output logic            rsp_wait,
  output logic [N-1:0]    ret_access,
  output logic [PW-1:0]   ret_packet,
  input  logic [N-1:0]    ret_wait,
  output logic            orphan
);

  localparam int unsigned ID_W = id_width(N);

  logic [PW-1:0]   pkt [N];
  logic [N-1:0]    eligible;
  logic            slot_free;
  logic            gnt_valid;
  logic [ID_W-1:0] gnt_idx;
  logic            fifo_full;
  logic            fifo_empty;
  logic [ID_W-1:0] head;
  logic            push;
  logic            pop;

  // Reads need a free ID slot to be eligible; writes never do.
  for (genvar i = 0; i < int'(N); i++) begin : g_req
    assign pkt[i]      = req_packet[i*PW +: PW];
    assign eligible[i] = req_access[i] & (pkt[i][WR_BIT] | ~fifo_full);
  end

  assign slot_free = ~spi_access | ~spi_wait;

`ifdef SPI_ARB_FIXED_PRIO_EN
  // Lowest-index eligible requester wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!gnt_valid && slot_free && eligible[ID_W'(k)]) begin
        gnt_valid = 1'b1;
        gnt_idx   = ID_W'(k);
      end
    end
  end
`else
  logic [ID_W-1:0] last_grant;
  int unsigned     cand;

  // Round-robin: search from last_grant+1, wrapping N-1 -> 0.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = (32'(last_grant) + k) % N;
      if (!gnt_valid && slot_free && eligible[ID_W'(cand)]) begin
        gnt_valid = 1'b1;
        gnt_idx   = ID_W'(cand);
      end
    end
  end

  // Reset to N-1 so requester 0 is searched first.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset)        last_grant <= ID_W'(N - 1);
    else if (gnt_valid) last_grant <= gnt_idx;
  end
`endif

  // Only the granted requester sees its pushback drop.
  always_comb begin
    req_wait = '1;
    if (gnt_valid) req_wait[gnt_idx] = 1'b0;
  end

  assign push = gnt_valid & ~pkt[gnt_idx][WR_BIT];
  assign pop  = rsp_access & ~fifo_empty & ~ret_wait[head];

  // Request slot and sticky orphan flag.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      spi_access <= 1'b0;
      orphan     <= 1'b0;
    end else begin
      if (slot_free)                 spi_access <= gnt_valid;
      if (rsp_access && fifo_empty)  orphan     <= 1'b1;
    end
  end

  // Packet payload is don't-care out of reset; it only loads on a grant.
  always_ff @(posedge clk) begin
    if (gnt_valid) spi_packet <= pkt[gnt_idx];
  end

  // Readback routing to the oldest outstanding reader; dropped when empty.
  always_comb begin
    ret_access = '0;
    if (rsp_access && !fifo_empty) ret_access[head] = 1'b1;
  end

  assign rsp_wait   = ~fifo_empty & ret_wait[head];
  assign ret_packet = rsp_packet;

  spi_arb_idfifo #(
    .W     (ID_W),
    .DEPTH (DEPTH)
  ) u_idfifo (
    .clk    (clk),
    .nreset (nreset),
    .push   (push),
    .din    (gnt_idx),
    .pop    (pop),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .head   (head)
  );

endmodule

// File: tb/tb_spi_master_arb.sv
// Scoreboard bench for spi_master_arb (N=2, PW=104, DEPTH=4).
// Expected SPI packets and readback routes are queued as stimulus is issued;
// a negedge monitor pops and compares whenever a transfer completes.
module tb_spi_master_arb;

  localparam int unsigned N     = 2;
  localparam int unsigned PW    = 104;
  localparam int unsigned DEPTH = 4;

  logic            clk = 1'b0;
  logic            nreset;
  logic [N-1:0]    req_access;
  logic [N*PW-1:0] req_packet;
  logic [N-1:0]    req_wait;
  logic            spi_access;
  logic [PW-1:0]   spi_packet;
  logic            spi_wait;
  logic            rsp_access;
  logic [PW-1:0]   rsp_packet;
  logic            rsp_wait;
  logic [N-1:0]    ret_access;
  logic [PW-1:0]   ret_packet;
  logic [N-1:0]    ret_wait;
  logic            orphan;

  logic [PW-1:0]   exp_spi [$];
  logic [N+PW-1:0] exp_ret [$];
  logic [PW-1:0]   src0 [$];
  logic [PW-1:0]   src1 [$];
  logic [PW-1:0]   mon_spi;
  logic [N+PW-1:0] mon_ret;
  int              n_tests = 0;
  int              n_fail  = 0;

  always #5 clk = ~clk;

  spi_master_arb #(.N(N), .PW(PW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .nreset     (nreset),
    .req_access (req_access),
    .req_packet (req_packet),
    .req_wait   (req_wait),
    .spi_access (spi_access),
    .spi_packet (spi_packet),
    .spi_wait   (spi_wait),
    .rsp_access (rsp_access),
    .rsp_packet (rsp_packet),
    .rsp_wait   (rsp_wait),
    .ret_access (ret_access),
    .ret_packet (ret_packet),
    .ret_wait   (ret_wait),
    .orphan     (orphan)
  );

  function automatic logic [PW-1:0] mk(input logic [7:0] req, input logic [7:0] k, input logic wr);
    logic [PW-1:0] p;
    p             = '0;
    p[0]          = wr;
    p[7:1]        = 7'h2A;
    p[15:8]       = req;
    p[23:16]      = k;
    p[PW-1:PW-8]  = 8'hC3;
    return p;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive both requesters from their source queues until all are granted.
  task automatic run_src(input int max_cyc);
    int         cyc;
    logic [1:0] g;
    cyc = 0;
    while ((src0.size() != 0 || src1.size() != 0) && cyc < max_cyc) begin
      req_access[0]          = (src0.size() != 0);
      req_access[1]          = (src1.size() != 0);
      req_packet[0*PW +: PW] = (src0.size() != 0) ? src0[0] : '0;
      req_packet[1*PW +: PW] = (src1.size() != 0) ? src1[0] : '0;
      @(negedge clk);
      g = req_access & ~req_wait;
      @(posedge clk); #1;
      if (g[0]) void'(src0.pop_front());
      if (g[1]) void'(src1.pop_front());
      cyc++;
    end
    req_access = '0;
    check("run_src_drained", 128'(src0.size() + src1.size()), 128'(0));
  endtask

  // Present one readback; optionally hold it with ret_wait for one cycle.
  task automatic send_rsp(input logic [PW-1:0] p, input logic [N-1:0] route, input logic hold);
    exp_ret.push_back({route, p});
    rsp_access = 1'b1;
    rsp_packet = p;
    ret_wait   = hold ? route : '0;
    if (hold) begin
      @(negedge clk);
      check("rsp_wait_held", 128'(rsp_wait), 128'(1));
      check("ret_access_held", 128'(ret_access), 128'(route));
      @(posedge clk); #1;
      ret_wait = '0;
    end
    @(posedge clk); #1;
    rsp_access = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Scoreboard monitor: compare every completed SPI transfer and readback.
  always @(negedge clk) begin
    if (nreset) begin
      if (spi_access && !spi_wait) begin
        if (exp_spi.size() == 0) begin
          check("spi_unexpected", 128'(spi_packet), 128'(0));
        end else begin
          mon_spi = exp_spi.pop_front();
          check("spi_packet", 128'(spi_packet), 128'(mon_spi));
        end
      end
      if (ret_access != '0 && !rsp_wait) begin
        if (exp_ret.size() == 0) begin
          check("ret_unexpected", 128'({ret_access, ret_packet}), 128'(0));
        end else begin
          mon_ret = exp_ret.pop_front();
          check("ret_route", 128'({ret_access, ret_packet}), 128'(mon_ret));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    nreset     = 1'b0;
    req_access = '0;
    req_packet = '0;
    spi_wait   = 1'b0;
    rsp_access = 1'b0;
    rsp_packet = '0;
    ret_wait   = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_spi_access", 128'(spi_access), 128'(0));
    check("rst_ret_access", 128'(ret_access), 128'(0));
    check("rst_orphan", 128'(orphan), 128'(0));
    check("rst_req_wait", 128'(req_wait), 128'(2'b11));
    check("rst_rsp_wait", 128'(rsp_wait), 128'(0));
    @(posedge clk); #1;
    nreset = 1'b1;
    gap(1);

    // Both requesters write continuously
    for (int k = 0; k < 3; k++) begin
      src0.push_back(mk(8'd0, 8'(k), 1'b1));
      src1.push_back(mk(8'd1, 8'(k), 1'b1));
    end
`ifdef SPI_ARB_FIXED_PRIO_EN
    for (int k = 0; k < 3; k++) exp_spi.push_back(mk(8'd0, 8'(k), 1'b1));
    for (int k = 0; k < 3; k++) exp_spi.push_back(mk(8'd1, 8'(k), 1'b1));
`else
    for (int k = 0; k < 3; k++) begin
      exp_spi.push_back(mk(8'd0, 8'(k), 1'b1));
      exp_spi.push_back(mk(8'd1, 8'(k), 1'b1));
    end
`endif
    run_src(20);
    gap(2);

    // Stall: slot held for 5 cycles under spi_wait
    spi_wait               = 1'b1;
    req_access             = 2'b11;
    req_packet[0*PW +: PW] = mk(8'd0, 8'h10, 1'b1);
    req_packet[1*PW +: PW] = mk(8'd1, 8'h11, 1'b1);
    exp_spi.push_back(mk(8'd0, 8'h10, 1'b1));
`ifdef SPI_ARB_FIXED_PRIO_EN
    exp_spi.push_back(mk(8'd0, 8'h12, 1'b1));
    exp_spi.push_back(mk(8'd1, 8'h11, 1'b1));
`else
    exp_spi.push_back(mk(8'd1, 8'h11, 1'b1));
    exp_spi.push_back(mk(8'd0, 8'h12, 1'b1));
`endif
    @(negedge clk);
    check("stall_first_grant", 128'(req_wait), 128'(2'b10));
    @(posedge clk); #1;
    req_packet[0*PW +: PW] = mk(8'd0, 8'h12, 1'b1);
    repeat (5) begin
      @(negedge clk);
      check("stall_access", 128'(spi_access), 128'(1));
      check("stall_packet", 128'(spi_packet), 128'(mk(8'd0, 8'h10, 1'b1)));
      check("stall_req_wait", 128'(req_wait), 128'(2'b11));
      @(posedge clk); #1;
    end
    spi_wait = 1'b0;
    src0.push_back(mk(8'd0, 8'h12, 1'b1));
    src1.push_back(mk(8'd1, 8'h11, 1'b1));
    run_src(20);
    gap(2);

    // Read routing: requester 1 reads, then requester 0
    src1.push_back(mk(8'd1, 8'h20, 1'b0));
    exp_spi.push_back(mk(8'd1, 8'h20, 1'b0));
    run_src(10);
    src0.push_back(mk(8'd0, 8'h21, 1'b0));
    exp_spi.push_back(mk(8'd0, 8'h21, 1'b0));
    run_src(10);
    gap(2);
    send_rsp(mk(8'hE1, 8'h01, 1'b0), 2'b10, 1'b1);
    send_rsp(mk(8'hE0, 8'h02, 1'b0), 2'b01, 1'b0);
    gap(2);

    // FIFO full: 4 reads outstanding, 5th read held, write still granted
    for (int k = 1; k <= 4; k++) begin
      src0.push_back(mk(8'd0, 8'(8'h30 + k), 1'b0));
      exp_spi.push_back(mk(8'd0, 8'(8'h30 + k), 1'b0));
    end
    run_src(20);
    req_access             = 2'b11;
    req_packet[0*PW +: PW] = mk(8'd0, 8'h35, 1'b0);
    req_packet[1*PW +: PW] = mk(8'd1, 8'h39, 1'b1);
    exp_spi.push_back(mk(8'd1, 8'h39, 1'b1));
    @(negedge clk);
    check("full_write_granted", 128'(req_wait), 128'(2'b01));
    @(posedge clk); #1;
    req_access = 2'b01;
    repeat (3) begin
      @(negedge clk);
      check("full_read_held", 128'(req_wait), 128'(2'b11));
      @(posedge clk); #1;
    end
    req_access = '0;
    gap(1);
    for (int k = 1; k <= 4; k++) send_rsp(mk(8'hD0, 8'(k), 1'b0), 2'b01, 1'b0);
    gap(2);

    // Reset mid-read discards the outstanding ID; readback then orphans
    src0.push_back(mk(8'd0, 8'h40, 1'b0));
    exp_spi.push_back(mk(8'd0, 8'h40, 1'b0));
    run_src(10);
    gap(1);
    nreset = 1'b0;
    @(negedge clk);
    check("midrst_spi_access", 128'(spi_access), 128'(0));
    check("midrst_ret_access", 128'(ret_access), 128'(0));
    @(posedge clk); #1;
    nreset     = 1'b1;
    rsp_access = 1'b1;
    rsp_packet = mk(8'hEE, 8'h00, 1'b0);
    @(negedge clk);
    check("orphan_ret_access", 128'(ret_access), 128'(0));
    check("orphan_rsp_wait", 128'(rsp_wait), 128'(0));
    check("orphan_before", 128'(orphan), 128'(0));
    @(posedge clk); #1;
    rsp_access = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("orphan_sticky", 128'(orphan), 128'(1));
      @(posedge clk); #1;
    end
    nreset = 1'b0;
    #1;
    check("orphan_cleared", 128'(orphan), 128'(0));
    check("exp_spi_drained", 128'(exp_spi.size()), 128'(0));
    check("exp_ret_drained", 128'(exp_ret.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
